// File: rtl/branch_update_queue_if.sv
// Bundled EX-side and predictor-side signals of the branch update queue.
// The slave modport is the queue's view of the bundle; the master modport is the environment's view.
interface branch_update_queue_if #(
  parameter int PTR_BITS = 2
);
  logic                ex_valid;
  logic [31:0]         ex_pc;
  logic                ex_taken;
  logic                ex_pred_taken;
  logic                ex_ready;
  logic                update_ready;
  logic                update_enable;
  logic [31:0]         update_pc;
  logic                taken;
  logic                mispredict;
  logic [PTR_BITS:0]   occupancy;
  logic [15:0]         mispredict_count;

  modport slave (
    input  ex_valid, ex_pc, ex_taken, ex_pred_taken, update_ready,
    output ex_ready, update_enable, update_pc, taken, mispredict,
           occupancy, mispredict_count
  );

  modport master (
    output ex_valid, ex_pc, ex_taken, ex_pred_taken, update_ready,
    input  ex_ready, update_enable, update_pc, taken, mispredict,
           occupancy, mispredict_count
  );
endinterface

// File: rtl/branch_update_queue.sv
// In-order FIFO of resolved branches replayed to the predictor as update writes.
// Optional mispredict statistics counter enabled by defining BUQ_MISPREDICT_STATS_EN.
module branch_update_queue #(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  branch_update_queue_if.slave  bus
);

  localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE    = PTR_BITS'(1);

  logic [31:0]         entryPc_q    [DEPTH];
  logic                entryTaken_q [DEPTH];
  logic [PTR_BITS-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_BITS-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_BITS:0]   count_q, count_d;
  logic                mispredict_q, mispredict_d;

  logic exReady;
  logic updEnable;
  logic pushEn;
  logic popEn;
  logic pushMiss;

  // Handshakes look only at the registered count, so a full queue never accepts a push even when popping.
  assign exReady   = (count_q != FULL_COUNT);
  assign updEnable = (count_q != '0);
  assign pushEn    = bus.ex_valid && exReady;
  assign popEn     = updEnable && bus.update_ready;
  assign pushMiss  = pushEn && (bus.ex_taken != bus.ex_pred_taken);

  always_comb begin
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    count_d      = count_q;
    mispredict_d = pushMiss;
    if (pushEn) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    if (pushEn && !popEn) begin
      count_d = count_q + 1'b1;
    end else if (popEn && !pushEn) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Entry storage is cleared on reset so the empty-queue head reads as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entryPc_q[i]    <= '0;
        entryTaken_q[i] <= 1'b0;
      end
    end else if (pushEn) begin
      entryPc_q[wrPtr_q]    <= bus.ex_pc;
      entryTaken_q[wrPtr_q] <= bus.ex_taken;
    end
  end

  assign bus.ex_ready      = exReady;
  assign bus.update_enable = updEnable;
  assign bus.update_pc     = entryPc_q[rdPtr_q];
  assign bus.taken         = entryTaken_q[rdPtr_q];
  assign bus.mispredict    = mispredict_q;
  assign bus.occupancy     = count_q;

`ifdef BUQ_MISPREDICT_STATS_EN
  logic [15:0] missCount_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      missCount_q <= '0;
    end else if (pushMiss && (missCount_q != 16'hFFFF)) begin
      missCount_q <= missCount_q + 16'd1;
    end
  end

  assign bus.mispredict_count = missCount_q;
`else
  assign bus.mispredict_count = 16'h0000;
`endif

endmodule
